// File: rtl/cache_set.sv
// One set of an 8-way set-associative write-allocate cache: tag match, true-LRU
// replacement, and 1/2/4/8-byte little-endian access within a 64-byte line.

module cache_way #(
  parameter int TAG_W      = 24,
  parameter int LINE_BYTES = 64,
  parameter int AGE_W      = 3,
  parameter int RST_AGE    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd,
  input  logic                         acc,
  input  logic [AGE_W-1:0]             acc_age,
  input  logic                         alloc,
  input  logic                         wr,
  input  logic [TAG_W-1:0]             tag_in,
  input  logic [LINE_BYTES-1:0]        byte_we,
  input  logic [LINE_BYTES-1:0][7:0]   wline,
  output logic                         valid,
  output logic [TAG_W-1:0]             tag,
  output logic [AGE_W-1:0]             age,
  output logic [LINE_BYTES-1:0][7:0]   line
);
  logic                       valid_q, valid_d;
  logic [AGE_W-1:0]           age_q, age_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [LINE_BYTES-1:0][7:0] line_q, line_d;

  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    tag_d   = tag_q;
    line_d  = line_q;
    // Ages form a permutation: the accessed way drops to 0, younger ways age by one.
    if (upd) begin
      if (acc)                  age_d = '0;
      else if (age_q < acc_age) age_d = age_q + AGE_W'(1);
    end
    if (acc && alloc) begin
      valid_d = 1'b1;
      tag_d   = tag_in;
      line_d  = '0;
    end
    if (acc && wr) begin
      for (int b = 0; b < LINE_BYTES; b++)
        if (byte_we[b]) line_d[b] = wline[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      age_q   <= AGE_W'(RST_AGE);
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign age   = age_q;
  assign line  = line_q;
endmodule

module cache_set #(
  parameter int WAYS       = 8,
  parameter int LINE_BYTES = 64,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [1:0]                    write_en,
  input  logic [$clog2(LINE_BYTES)-1:0] block_offset,
  input  logic [63:0]                   write_data,
  input  logic [1:0]                    data_size,
  input  logic [TAG_W-1:0]              tag,
  input  logic [31:0]                   num_ops,
  output logic [63:0]                   out_data,
  output logic                          miss,
  output logic                          data_ready
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int WAY_W = $clog2(WAYS);
  localparam int AGE_W = $clog2(WAYS);

  logic                                   req_vld, is_wr;
  logic [WAYS-1:0]                        way_valid, hit_vec, acc_vec;
  logic [WAYS-1:0][TAG_W-1:0]             way_tag;
  logic [WAYS-1:0][AGE_W-1:0]             way_age;
  logic [WAYS-1:0][LINE_BYTES-1:0][7:0]   way_line;
  logic                                   hit_any, inv_any;
  logic [WAY_W-1:0]                       hit_idx, inv_idx, lru_idx, acc_idx;
  logic [AGE_W-1:0]                       acc_age;
  logic [LINE_BYTES-1:0][7:0]             hit_line, wline;
  logic [LINE_BYTES-1:0]                  byte_we;
  logic [63:0]                            rd_data;
  logic [3:0]                             nbytes;
  logic [OFF_W:0]                         pos;
  logic [63:0]                            out_data_q, out_data_d;
  logic                                   miss_q, miss_d;
  logic                                   data_ready_q, data_ready_d;
  logic                                   unused_num_ops;

  assign unused_num_ops = ^num_ops;
  assign req_vld = enable && !write_en[1];
  assign is_wr   = (write_en == 2'b01);

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_valid[i] && way_tag[i] == tag) begin
        hit_vec[i] = 1'b1;
        hit_any    = 1'b1;
        hit_idx    = WAY_W'(i);
      end
    end
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(i);
      end
    end
    lru_idx = '0;
    for (int i = 0; i < WAYS; i++)
      if (way_age[i] == AGE_W'(WAYS-1)) lru_idx = WAY_W'(i);
    acc_idx  = hit_any ? hit_idx : (inv_any ? inv_idx : lru_idx);
    acc_age  = way_age[acc_idx];
    hit_line = hit_any ? way_line[hit_idx] : '0;
    acc_vec  = '0;
    if (req_vld) acc_vec[acc_idx] = 1'b1;
  end

  // Byte lane k of the request maps to line byte offset+k; lanes past the line end drop out.
  always_comb begin
    nbytes  = 4'd1 << data_size;
    byte_we = '0;
    wline   = '0;
    rd_data = '0;
    pos     = '0;
    for (int k = 0; k < 8; k++) begin
      pos = {1'b0, block_offset} + (OFF_W+1)'(k);
      if (k < 32'(nbytes) && pos < (OFF_W+1)'(LINE_BYTES)) begin
        byte_we[pos[OFF_W-1:0]] = 1'b1;
        wline[pos[OFF_W-1:0]]   = write_data[8*k +: 8];
        rd_data[8*k +: 8]       = hit_line[pos[OFF_W-1:0]];
      end
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    cache_way #(
      .TAG_W      (TAG_W),
      .LINE_BYTES (LINE_BYTES),
      .AGE_W      (AGE_W),
      .RST_AGE    (WAYS-1-i)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd     (req_vld),
      .acc     (acc_vec[i]),
      .acc_age (acc_age),
      .alloc   (!hit_any),
      .wr      (is_wr),
      .tag_in  (tag),
      .byte_we (byte_we),
      .wline   (wline),
      .valid   (way_valid[i]),
      .tag     (way_tag[i]),
      .age     (way_age[i]),
      .line    (way_line[i])
    );
  end

  // out_data is the read-result register; writes leave it untouched.
  always_comb begin
    out_data_d   = out_data_q;
    miss_d       = miss_q;
    data_ready_d = 1'b0;
    if (req_vld) begin
      data_ready_d = 1'b1;
      miss_d       = !hit_any;
      if (!is_wr) out_data_d = hit_any ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      miss_q       <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      miss_q       <= miss_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign out_data   = out_data_q;
  assign miss       = miss_q;
  assign data_ready = data_ready_q;

  a_onehot_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_vec));
endmodule

// File: tb/tb_cache_set.sv
// Directed vector bench for cache_set: table-driven accesses plus hand-written reset sequences.

module tb_cache_set;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  write_en = 2'd0;
  logic [5:0]  block_offset = '0;
  logic [63:0] write_data = '0;
  logic [1:0]  data_size = '0;
  logic [23:0] tag = '0;
  logic [31:0] num_ops = '0;
  logic [63:0] out_data;
  logic        miss, data_ready;

  int checks = 0;
  int errors = 0;

  cache_set dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .write_en(write_en),
    .block_offset(block_offset), .write_data(write_data), .data_size(data_size),
    .tag(tag), .num_ops(num_ops), .out_data(out_data), .miss(miss), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  we;
    logic [23:0] tg;
    logic [5:0]  off;
    logic [1:0]  sz;
    logic [63:0] wd;
    logic        chk_out;
    logic [63:0] eout;
    logic        emiss;
    logic        erdy;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  function automatic vec_t mk(logic en, logic [1:0] we, logic [23:0] tg, logic [5:0] off,
                              logic [1:0] sz, logic [63:0] wd, logic chk_out,
                              logic [63:0] eout, logic emiss, logic erdy);
    vec_t v;
    v.en = en; v.we = we; v.tg = tg; v.off = off; v.sz = sz; v.wd = wd;
    v.chk_out = chk_out; v.eout = eout; v.emiss = emiss; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tname, input int idx, input vec_t v);
    @(negedge clk);
    enable = v.en; write_en = v.we; tag = v.tg; block_offset = v.off;
    data_size = v.sz; write_data = v.wd; num_ops = num_ops + 1;
    @(posedge clk);
    #1;
    if (v.chk_out) chk($sformatf("%s[%0d].out_data", tname, idx), out_data, v.eout);
    chk($sformatf("%s[%0d].miss", tname, idx), 64'(miss), 64'(v.emiss));
    chk($sformatf("%s[%0d].data_ready", tname, idx), 64'(data_ready), 64'(v.erdy));
  endtask

  initial begin
    // en, we, tag, off, sz, wdata, chk_out, exp_out, exp_miss, exp_rdy
    tbl1.push_back(mk(1, 1, 16,  0, 0, 64'h3,                0, 0,                     1, 1));
    tbl1.push_back(mk(1, 0, 16,  0, 0, 0,                    1, 64'h3,                 0, 1));
    tbl1.push_back(mk(1, 1, 25,  0, 0, 64'h8,                0, 0,                     1, 1));
    tbl1.push_back(mk(1, 0, 15,  0, 3, 0,                    1, 64'h0,                 1, 1));
    tbl1.push_back(mk(1, 0, 25,  0, 0, 0,                    1, 64'h8,                 0, 1));
    tbl1.push_back(mk(1, 1, 16,  8, 3, 64'h1122334455667788, 0, 0,                     0, 1));
    tbl1.push_back(mk(1, 0, 16, 10, 1, 0,                    1, 64'h5566,              0, 1));
    tbl1.push_back(mk(1, 0, 16,  8, 2, 0,                    1, 64'h55667788,          0, 1));
    tbl1.push_back(mk(1, 0, 16, 15, 0, 0,                    1, 64'h11,                0, 1));
    tbl1.push_back(mk(1, 1, 16, 62, 2, 64'hAABBCCDD,         0, 0,                     0, 1));
    tbl1.push_back(mk(1, 0, 16, 62, 1, 0,                    1, 64'hCCDD,              0, 1));
    tbl1.push_back(mk(1, 0, 16, 56, 3, 0,                    1, 64'hCCDD000000000000,  0, 1));
    tbl1.push_back(mk(1, 2, 16,  0, 0, 64'hFF,               1, 64'hCCDD000000000000,  0, 0));
    tbl1.push_back(mk(0, 0, 99,  0, 0, 0,                    1, 64'hCCDD000000000000,  0, 0));
    tbl1.push_back(mk(1, 3, 200, 0, 0, 64'h77,               1, 64'hCCDD000000000000,  0, 0));
    tbl1.push_back(mk(1, 0, 16,  0, 3, 0,                    1, 64'h3,                 0, 1));
    tbl1.push_back(mk(1, 0, 200, 0, 0, 0,                    1, 64'h0,                 1, 1));
    tbl1.push_back(mk(1, 0, 15,  0, 3, 0,                    1, 64'h0,                 0, 1));
    tbl1.push_back(mk(1, 0, 16,  0, 0, 0,                    1, 64'h3,                 0, 1));

    // After mid-sequence reset: tag 16 gone, then fill/evict with true LRU.
    tbl2.push_back(mk(1, 0, 16, 0, 0, 0, 1, 64'h0, 1, 1));
    for (int t = 1; t <= 8; t++)
      tbl2.push_back(mk(1, 1, 24'(t), 0, 0, 64'(t), 0, 0, 1, 1));
    tbl2.push_back(mk(1, 0, 1, 0, 0, 0,     1, 64'h1, 0, 1));
    tbl2.push_back(mk(1, 1, 9, 0, 0, 64'h9, 0, 0,     1, 1));
    tbl2.push_back(mk(1, 0, 2, 0, 0, 0,     1, 64'h0, 1, 1));
    tbl2.push_back(mk(1, 0, 1, 0, 0, 0,     1, 64'h1, 0, 1));
    tbl2.push_back(mk(1, 0, 9, 0, 0, 0,     1, 64'h9, 0, 1));
    tbl2.push_back(mk(1, 0, 8, 0, 0, 0,     1, 64'h8, 0, 1));
    tbl2.push_back(mk(1, 0, 3, 0, 0, 0,     1, 64'h0, 1, 1));
    tbl2.push_back(mk(1, 0, 16, 0, 0, 0,    1, 64'h0, 1, 1));
    tbl2.push_back(mk(1, 0, 4, 0, 0, 0,     1, 64'h0, 1, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_data", out_data, 64'h0);
    chk("reset.miss", 64'(miss), 64'h0);
    chk("reset.data_ready", 64'(data_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl1.size(); i++) run_vec("t1", i, tbl1[i]);

    // Reset asserted mid-cycle while a write is being presented.
    @(negedge clk);
    enable = 1'b1; write_en = 2'd1; tag = 16; block_offset = 0; data_size = 0; write_data = 64'h55;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_data", out_data, 64'h0);
    chk("midrst.miss", 64'(miss), 64'h0);
    chk("midrst.data_ready", 64'(data_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("midrst_edge.out_data", out_data, 64'h0);
    chk("midrst_edge.data_ready", 64'(data_ready), 64'h0);
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl2.size(); i++) run_vec("t2", i, tbl2[i]);

    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.data_ready", 64'(data_ready), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
